// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to packed BCD converter with valid/ready handshakes
module bin2bcd_seq #(
  parameter int W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  state_t state, state_n;
  logic [W-1:0] sh;
  logic [BW-1:0] acc, adj, acc_n;
  logic [CW-1:0] cnt;
  logic last;
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign adj[4*d +: 4] = acc[4*d +: 4] >= 4'd5 ? acc[4*d +: 4] + 4'd3 : acc[4*d +: 4];
  end
  assign acc_n = {adj[BW-2:0], sh[W-1]};
  assign last = cnt == CW'(W - 1);
  assign in_ready = state == IDLE;
  assign busy = state == SHIFT;
  assign out_valid = state == HOLD;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE  ? (in_valid ? SHIFT : IDLE) :
              state == SHIFT ? (last ? HOLD : SHIFT) :
                               (out_ready ? IDLE : HOLD);
  // bcd only changes on the final shift, so it keeps the last result through IDLE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh  <= '0;
      acc <= '0;
      cnt <= '0;
      bcd <= '0;
    end else if (state == IDLE && in_valid) begin
      sh  <= bin;
      acc <= '0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      sh  <= {sh[W-2:0], 1'b0};
      acc <= acc_n;
      cnt <= cnt + 1'b1;
      if (last) bcd <= acc_n;
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and exhaustive checks of bin2bcd_seq against an arithmetic BCD model
module tb_bin2bcd_seq;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [7:0] bin = '0;
  logic in_ready, out_valid, busy;
  logic [11:0] bcd;
  int passed = 0, total = 0;

  bin2bcd_seq #(.W(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one full transaction: accept v, wait for result, stall, optionally poke in_valid during HOLD
  task automatic conv(input int v, input int stall, input bit poke);
    int n = 0;
    while (!in_ready && n < 40) begin step(); n++; end
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1;
    bin = 8'(v);
    step();
    in_valid = 0;
    bin = 8'($urandom);
    check("busy_after_accept", busy, 1);
    check("in_ready_in_shift", in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      if (n == 2) in_valid = 1;
      step();
      in_valid = 0;
      n++;
    end
    check("latency", n, 8);
    check($sformatf("bcd_%0d", v), bcd, ref_bcd(v));
    check("in_ready_in_hold", in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      if (poke && i == 1) begin in_valid = 1; bin = 8'd77; end
      step();
      in_valid = 0;
      check("hold_valid", out_valid, 1);
      check("hold_bcd_stable", bcd, ref_bcd(v));
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    step();
    out_ready = 0;
    check("valid_drops_after_handshake", out_valid, 0);
    check("in_ready_after_handshake", in_ready, 1);
    check("bcd_kept_after_handshake", bcd, ref_bcd(v));
    if (poke) begin
      step();
      check("hold_poke_not_captured", busy, 0);
    end
  endtask

  initial begin
    #2;
    check("reset_bcd", bcd, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    rst = 0;
    step();
    check("idle_in_ready", in_ready, 1);
    conv(0, 0, 0);
    conv(225, 1, 0);
    conv(255, 0, 0);
    conv(99, 0, 0);
    conv(100, 0, 0);
    conv(42, 5, 1);
    in_valid = 1;
    bin = 8'd200;
    step();
    in_valid = 0;
    repeat (3) step();
    check("busy_before_reset", busy, 1);
    rst = 1;
    #1;
    check("rst_bcd", bcd, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    step();
    rst = 0;
    step();
    conv(137, 0, 0);
    for (int v = 0; v < 256; v++) conv(v, int'($urandom_range(0, 3)), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $fatal(1, "FAIL timeout: simulation did not finish");
  end
endmodule
